// File: rtl/usart_engine.sv
// usart_engine: compact USART with oversampled transmitter and receiver,
// each side buffered by a small FIFO.
//
// Optional feature macro: USART_PARITY_EN
//   defined   -> Par/Odd select a parity bit after the data bits (TX and RX),
//                RX parity mismatches raise PE.
//   undefined -> Par/Odd are ignored, frames never carry a parity bit, PE is 0.
//
// Ports
//   CPU_Clk            sole clock (rising edge)
//   Reset              synchronous, active-high
//   Divisor[DIV_W]     oversample tick every Divisor+1 clocks
//   Par, Odd, Stop2    frame format, sampled at each frame start
//   WR, WR_Data        push one word into the TX FIFO
//   RD, RD_Data        pop the RX FIFO head; RD_Data is the show-ahead head
//   TxD / RxD          serial out (idle high) / serial in (asynchronous)
//   TxFull, TxEmpty    TX FIFO status
//   RxAV               RX FIFO non-empty
//   Busy               TX FSM not idle
//   OV, FE, PE         sticky overrun / framing / parity flags, cleared by RD
module usart_engine #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic              CPU_Clk,
  input  logic              Reset,
  input  logic [DIV_W-1:0]  Divisor,
  input  logic              Par,
  input  logic              Odd,
  input  logic              Stop2,
  input  logic              WR,
  input  logic [DATA_W-1:0] WR_Data,
  input  logic              RD,
  output logic [DATA_W-1:0] RD_Data,
  output logic              TxD,
  input  logic              RxD,
  output logic              TxFull,
  output logic              TxEmpty,
  output logic              RxAV,
  output logic              Busy,
  output logic              OV,
  output logic              FE,
  output logic              PE
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic par_en;
  logic odd_en;
`ifdef USART_PARITY_EN
  assign par_en = Par;
  assign odd_en = Odd;
`else
  logic cfg_unused;
  assign par_en     = 1'b0;
  assign odd_en     = 1'b0;
  assign cfg_unused = Par ^ Odd;
`endif

  // Tick generator: the period is latched at each reload so a Divisor change
  // never truncates or stretches the period in progress.
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  assign tick = (tick_cnt_q == div_q);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    div_d      = tick ? Divisor : div_q;
  end

  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      tick_cnt_q <= '0;
      div_q      <= Divisor;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      div_q      <= div_d;
    end
  end

  // TX FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_head;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                    (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
  // Fullness is judged before any same-cycle pop.
  assign tx_push  = WR & ~tx_full;

  always_comb begin
    tx_wp_d = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
    tx_rp_d = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
  end

  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
    end
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= WR_Data;
  end

  // TX FSM
  state_t            tx_state_q;
  logic [4:0]        tx_cnt_q;
  logic [BW-1:0]     tx_bit_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic              tx_par_q, tx_stop2_q, tx_pbit_q, txd_q;
  logic [4:0]        tx_stop_last;

  assign tx_stop_last = tx_stop2_q ? 5'd31 : 5'd15;
  // A new frame starts from IDLE or directly out of the last stop tick,
  // which keeps back-to-back frames gap-free.
  assign tx_pop = tick & ~tx_empty &
                  ((tx_state_q == S_IDLE) ||
                   ((tx_state_q == S_STOP) && (tx_cnt_q == tx_stop_last)));

  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_par_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      txd_q      <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q <= S_START;
      tx_cnt_q   <= '0;
      tx_sh_q    <= tx_head;
      tx_par_q   <= par_en;
      tx_stop2_q <= Stop2;
      tx_pbit_q  <= (^tx_head) ^ odd_en;
      txd_q      <= 1'b0;
    end else if (tick) begin
      case (tx_state_q)
        S_START: begin
          if (tx_cnt_q == 5'd15) begin
            tx_state_q <= S_DATA;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_sh_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 5'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == 5'd15) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == LAST_BIT) begin
              tx_state_q <= tx_par_q ? S_PARITY : S_STOP;
              txd_q      <= tx_par_q ? tx_pbit_q : 1'b1;
            end else begin
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q + 1'b1;
              txd_q    <= tx_sh_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 5'd1;
          end
        end
        S_PARITY: begin
          if (tx_cnt_q == 5'd15) begin
            tx_state_q <= S_STOP;
            tx_cnt_q   <= '0;
            txd_q      <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 5'd1;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == tx_stop_last) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
          end else begin
            tx_cnt_q <= tx_cnt_q + 5'd1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // RxD synchronizer
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX FSM: samples at bit centres, 8 ticks into START then every 16 ticks.
  state_t            rx_state_q;
  logic [4:0]        rx_cnt_q;
  logic [BW-1:0]     rx_bit_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic              rx_par_q, rx_odd_q, rx_perr_q;
  logic              rx_stop_samp, fe_evt, pe_evt;

  assign rx_stop_samp = tick && (rx_state_q == S_STOP) && (rx_cnt_q == 5'd15);
  assign fe_evt       = rx_stop_samp & ~rx_sync_q;
  assign pe_evt       = rx_stop_samp & rx_par_q & rx_perr_q;

  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_par_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
    end else if (tick) begin
      case (rx_state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= S_START;
            rx_cnt_q   <= '0;
            rx_par_q   <= par_en;
            rx_odd_q   <= odd_en;
            rx_perr_q  <= 1'b0;
          end
        end
        S_START: begin
          if (rx_cnt_q == 5'd7) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            // A line that is high again at mid-start was only a glitch.
            rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 5'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == 5'd15) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_sync_q, rx_sh_q[DATA_W-1:1]};
            if (rx_bit_q == LAST_BIT) begin
              rx_state_q <= rx_par_q ? S_PARITY : S_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 5'd1;
          end
        end
        S_PARITY: begin
          if (rx_cnt_q == 5'd15) begin
            rx_state_q <= S_STOP;
            rx_cnt_q   <= '0;
            rx_perr_q  <= rx_sync_q ^ (^rx_sh_q) ^ rx_odd_q;
          end else begin
            rx_cnt_q <= rx_cnt_q + 5'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == 5'd15) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
          end else begin
            rx_cnt_q <= rx_cnt_q + 5'd1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // RX FIFO and sticky flags
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic              rx_push, rx_pop, rx_full, rx_empty, ov_evt;
  logic [DATA_W-1:0] rx_head;
  logic [DATA_W-1:0] last_q, last_d;
  logic              ov_q, ov_d, fe_q, fe_d, pe_q, pe_d;

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                    (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign rx_head  = rx_mem[rx_rp_q[AW-1:0]];
  assign rx_push  = rx_stop_samp & ~rx_full;
  assign ov_evt   = rx_stop_samp & rx_full;
  assign rx_pop   = RD & ~rx_empty;

  always_comb begin
    rx_wp_d = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
    // A new error event in the same cycle as the clearing read wins.
    ov_d    = ov_evt | (ov_q & ~rx_pop);
    fe_d    = fe_evt | (fe_q & ~rx_pop);
    pe_d    = pe_evt | (pe_q & ~rx_pop);
    // Remember the last popped word so RD_Data holds once the FIFO drains.
    last_d  = rx_pop ? rx_head : last_q;
  end

  always_ff @(posedge CPU_Clk) begin
    if (Reset) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      last_q  <= '0;
    end else begin
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      ov_q    <= ov_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      last_q  <= last_d;
    end
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
  end

  assign RD_Data = rx_empty ? last_q : rx_head;
  assign TxD     = txd_q;
  assign TxFull  = tx_full;
  assign TxEmpty = tx_empty;
  assign RxAV    = ~rx_empty;
  assign Busy    = (tx_state_q != S_IDLE);
  assign OV      = ov_q;
  assign FE      = fe_q;
  assign PE      = pe_q;

endmodule

// File: tb/tb_usart_engine.sv
// tb_usart_engine: directed, table-driven bench for usart_engine
// (DATA_W=8, FIFO_DEPTH=4). Runs with or without USART_PARITY_EN.
module tb_usart_engine;

  logic        CPU_Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Divisor = 16'd0;
  logic        Par = 1'b0, Odd = 1'b0, Stop2 = 1'b0;
  logic        WR = 1'b0, RD = 1'b0;
  logic [7:0]  WR_Data = 8'd0;
  logic [7:0]  RD_Data;
  logic        TxD, RxD;
  logic        TxFull, TxEmpty, RxAV, Busy, OV, FE, PE;
  logic        loop_en = 1'b0;
  logic        rxd_drv = 1'b1;

  int tests = 0;
  int fails = 0;

  assign RxD = loop_en ? TxD : rxd_drv;

  always #5 CPU_Clk = ~CPU_Clk;

  usart_engine dut (
    .CPU_Clk(CPU_Clk), .Reset(Reset), .Divisor(Divisor),
    .Par(Par), .Odd(Odd), .Stop2(Stop2),
    .WR(WR), .WR_Data(WR_Data), .RD(RD), .RD_Data(RD_Data),
    .TxD(TxD), .RxD(RxD),
    .TxFull(TxFull), .TxEmpty(TxEmpty), .RxAV(RxAV), .Busy(Busy),
    .OV(OV), .FE(FE), .PE(PE)
  );

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        odd;
    logic        stop2;
    logic [15:0] div;
    logic [11:0] bits;   // expected line level per bit time, start bit first
    int          nbits;
  } tx_vec_t;

  tx_vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CPU_Clk);
  endtask

  task automatic write_word(input logic [7:0] d);
    WR = 1'b1; WR_Data = d;
    @(negedge CPU_Clk);
    WR = 1'b0;
  endtask

  task automatic pulse_rd();
    RD = 1'b1;
    @(negedge CPU_Clk);
    RD = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic with_par,
                          input logic pbit, input logic stopb);
    rxd_drv = 1'b0; cycles(16);
    for (int i = 0; i < 8; i++) begin rxd_drv = d[i]; cycles(16); end
    if (with_par) begin rxd_drv = pbit; cycles(16); end
    rxd_drv = stopb; cycles(16);
    rxd_drv = 1'b1; cycles(24);
  endtask

  task automatic wait_rxav(input string name, input int budget);
    int n = 0;
    while (!RxAV && n < budget) begin @(negedge CPU_Clk); n++; end
    check(name, RxAV, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w, cyc, bp, bad;
    logic [11:0] cap;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd0, 12'h34A, 10};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 16'd0, 12'h678, 11};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 16'd2, 12'h2AA, 10};
`ifdef USART_PARITY_EN
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 16'd0, 12'h478, 11};
    vecs[4] = '{8'h03, 1'b1, 1'b1, 1'b0, 16'd0, 12'h606, 11};
`else
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 16'd0, 12'h278, 10};
    vecs[4] = '{8'h03, 1'b1, 1'b1, 1'b0, 16'd0, 12'h206, 10};
`endif

    // Reset state
    cycles(4);
    check("rst_txd", TxD, 1);
    check("rst_busy", Busy, 0);
    check("rst_txempty", TxEmpty, 1);
    check("rst_txfull", TxFull, 0);
    check("rst_rxav", RxAV, 0);
    check("rst_flags", {OV, FE, PE}, 0);
    check("rst_rddata", RD_Data, 0);
    Reset = 1'b0;
    cycles(2);

    // Transmit frames from the table
    for (int i = 0; i < 5; i++) begin
      Divisor = vecs[i].div; Par = vecs[i].par; Odd = vecs[i].odd; Stop2 = vecs[i].stop2;
      bp = 16 * (int'(vecs[i].div) + 1);
      cycles(8);
      write_word(vecs[i].data);
      w = 0;
      while (!Busy && w < 200) begin @(negedge CPU_Clk); w++; end
      check($sformatf("tx%0d_start", i), Busy, 1);
      cap = '0; cyc = 0;
      while (Busy && cyc < 4000) begin
        if ((cyc % bp) == bp / 2 && cyc / bp < 12) cap[cyc / bp] = TxD;
        @(negedge CPU_Clk);
        cyc++;
      end
      check($sformatf("tx%0d_bits", i), cap, vecs[i].bits);
      check($sformatf("tx%0d_busy_len", i), cyc, vecs[i].nbits * bp);
      check($sformatf("tx%0d_idle", i), TxD, 1);
    end
    Divisor = 16'd0; Par = 1'b0; Odd = 1'b0; Stop2 = 1'b0;
    cycles(8);

    // Loopback with parity requested
    loop_en = 1'b1; Par = 1'b1; Odd = 1'b0;
    cycles(4);
    write_word(8'h3C);
    wait_rxav("lb_rxav", 400);
    check("lb_data", RD_Data, 8'h3C);
    check("lb_pe_fe", {PE, FE}, 0);
    w = 0;
    while (Busy && w < 100) begin @(negedge CPU_Clk); w++; end
    pulse_rd();
    check("lb_drained", RxAV, 0);
    loop_en = 1'b0;
    cycles(8);

    // Injected parity error (or parity ignored when the feature is absent)
`ifdef USART_PARITY_EN
    rx_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check("pe_set", PE, 1);
    check("pe_fe", FE, 0);
`else
    rx_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check("pe_tied", PE, 0);
`endif
    check("pe_rxav", RxAV, 1);
    check("pe_data", RD_Data, 8'h3C);
    pulse_rd();
    check("pe_cleared", PE, 0);
    check("pe_drained", RxAV, 0);
    Par = 1'b0;
    cycles(4);

    // Framing error, then a short glitch, then a good frame
    rx_frame(8'h81, 1'b0, 1'b0, 1'b0);
    check("fe_set", FE, 1);
    check("fe_data", RD_Data, 8'h81);
    pulse_rd();
    check("fe_cleared", FE, 0);
    check("fe_no_extra", RxAV, 0);
    rxd_drv = 1'b0; cycles(5);
    rxd_drv = 1'b1; cycles(30);
    check("glitch_no_push", RxAV, 0);
    rx_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("after_glitch_rxav", RxAV, 1);
    check("after_glitch_data", RD_Data, 8'h5A);
    check("after_glitch_fe", FE, 0);
    pulse_rd();

    // Overrun: five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b0, 1'b0, 1'b1);
    check("ov_set", OV, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ov_read%0d", i), RD_Data, i);
      pulse_rd();
      if (i == 1) check("ov_cleared", OV, 0);
    end
    check("ov_empty", RxAV, 0);
    check("ov_hold", RD_Data, 8'h04);
    pulse_rd();
    check("ov_hold_rd", RD_Data, 8'h04);
    check("ov_still_empty", RxAV, 0);

    // TX FIFO full, ignored write, then back-to-back frames via loopback
    loop_en = 1'b1;
    Divisor = 16'd1000;
    cycles(2);
    write_word(8'h11); write_word(8'h22); write_word(8'h33); write_word(8'h44);
    check("txf_full", TxFull, 1);
    check("txf_not_empty", TxEmpty, 0);
    check("txf_not_busy", Busy, 0);
    write_word(8'hEE);
    check("txf_still_full", TxFull, 1);
    Divisor = 16'd0;
    w = 0;
    while (!Busy && w < 1200) begin @(negedge CPU_Clk); w++; end
    check("txf_start", Busy, 1);
    cyc = 0;
    while (Busy && cyc < 2000) begin @(negedge CPU_Clk); cyc++; end
    check("txf_b2b_len", cyc, 640);
    check("txf_empty", TxEmpty, 1);
    cycles(4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("txf_rx%0d", i), RD_Data, 8'(i * 8'h11));
      pulse_rd();
    end
    check("txf_rx_drained", RxAV, 0);

    // Reset in the middle of a TX frame with more words queued
    write_word(8'hA1); write_word(8'hA2); write_word(8'hA3);
    cycles(60);
    check("mid_busy", Busy, 1);
    Reset = 1'b1;
    @(negedge CPU_Clk);
    check("mid_rst_txd", TxD, 1);
    check("mid_rst_txempty", TxEmpty, 1);
    check("mid_rst_busy", Busy, 0);
    Reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CPU_Clk);
      if (Busy || !TxD || RxAV) bad++;
    end
    check("mid_rst_quiet", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
